// File: rtl/tdc_multichannel.sv
// Multichannel time-to-digital converter. Each stop input is synchronized,
// debounced and edge-detected, then the first qualifying edge latches the shared run counter.
module tdc_multichannel #(
    parameter int CH          = 4,
    parameter int W           = 8,
    parameter int SYNC_STAGES = 3,
    parameter int DEB_LEN     = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            edge_sel,
    input  logic [CH-1:0]   ch_in,
    input  logic            ack,
    output logic            ready,
    output logic            running,
    output logic            valid,
    output logic [CH-1:0]   hit,
    output logic            overflow,
    output logic [CH*W-1:0] count_out
);
    localparam logic [W-1:0]   CNT_MAX   = {W{1'b1}};
    localparam int             DW        = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [DW-1:0]  DEB_LAST  = DW'(DEB_LEN - 1);
    localparam int             WUW       = $clog2(SYNC_STAGES + 2);
    localparam logic [WUW-1:0] WARM_DONE = WUW'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0][CH-1:0] sync_r;
    logic [CH-1:0]                  sync_out_s;
    logic [WUW-1:0]                 warm_r;
    logic                           primed_s;
    logic [CH-1:0][DW-1:0]          deb_cnt_r;
    logic [CH-1:0]                  deb_r;
    logic [CH-1:0]                  deb_prev_r;
    logic [CH-1:0]                  det_s;

    state_t                         state_r;
    logic [W-1:0]                   cnt_r;
    logic [CH-1:0]                  hit_r;
    logic [CH-1:0][W-1:0]           cap_r;
    logic                           ovf_r;
    logic                           edge_sel_r;
    logic                           ready_r;
    logic                           running_r;
    logic                           valid_r;

    logic [CH-1:0]                  hit_next_s;
    logic [CH-1:0][W-1:0]           cap_next_s;
    logic                           all_hit_s;
    logic                           sat_s;

    assign sync_out_s = sync_r[SYNC_STAGES-1];
    assign primed_s   = (warm_r == WARM_DONE);

    // Synchronizer shift chain, one lane per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '0;
        end else begin
            sync_r[0] <= ch_in;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Post-reset warm-up: wait until the synchronizer holds real input samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_r <= '0;
        end else if (warm_r != WARM_DONE) begin
            warm_r <= warm_r + WUW'(1);
        end else begin
            warm_r <= warm_r;
        end
    end

    // Debounce and edge history; seeded straight from the synchronizer during warm-up
    // so a level already present at reset release never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_r      <= '0;
            deb_prev_r <= '0;
            deb_cnt_r  <= '0;
        end else if (!primed_s) begin
            deb_r      <= sync_out_s;
            deb_prev_r <= sync_out_s;
            deb_cnt_r  <= '0;
        end else begin
            deb_prev_r <= deb_r;
            for (int i = 0; i < CH; i++) begin
                if (sync_out_s[i] == deb_r[i]) begin
                    deb_cnt_r[i] <= '0;
                end else if (deb_cnt_r[i] == DEB_LAST) begin
                    deb_r[i]     <= sync_out_s[i];
                    deb_cnt_r[i] <= '0;
                end else begin
                    deb_cnt_r[i] <= deb_cnt_r[i] + DW'(1);
                end
            end
        end
    end

    // One-cycle detect pulse on the debounced edge of the latched polarity
    always_comb begin
        det_s = '0;
        if (primed_s) begin
            if (edge_sel_r) begin
                det_s = deb_prev_r & ~deb_r;
            end else begin
                det_s = deb_r & ~deb_prev_r;
            end
        end else begin
            det_s = '0;
        end
    end

    // Capture next-state: first edge wins, unhit channels pinned to full scale on saturation
    always_comb begin
        hit_next_s = hit_r;
        cap_next_s = cap_r;
        for (int i = 0; i < CH; i++) begin
            if (det_s[i] && !hit_r[i]) begin
                hit_next_s[i] = 1'b1;
                cap_next_s[i] = cnt_r;
            end else begin
                hit_next_s[i] = hit_r[i];
            end
        end
        all_hit_s = &hit_next_s;
        sat_s     = (cnt_r == CNT_MAX);
        for (int i = 0; i < CH; i++) begin
            if (sat_s && !hit_next_s[i]) begin
                cap_next_s[i] = CNT_MAX;
            end else begin
                cap_next_s[i] = cap_next_s[i];
            end
        end
    end

    // Measurement FSM with registered status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= S_IDLE;
            cnt_r      <= '0;
            hit_r      <= '0;
            cap_r      <= '0;
            ovf_r      <= 1'b0;
            edge_sel_r <= 1'b0;
            ready_r    <= 1'b1;
            running_r  <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        cnt_r      <= '0;
                        hit_r      <= '0;
                        cap_r      <= '0;
                        ovf_r      <= 1'b0;
                        edge_sel_r <= edge_sel;
                        state_r    <= S_RUN;
                        ready_r    <= 1'b0;
                        running_r  <= 1'b1;
                    end
                end
                S_RUN: begin
                    hit_r <= hit_next_s;
                    cap_r <= cap_next_s;
                    if (all_hit_s || sat_s) begin
                        ovf_r     <= ~all_hit_s;
                        state_r   <= S_DONE;
                        running_r <= 1'b0;
                        valid_r   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + W'(1);
                    end
                end
                S_DONE: begin
                    if (ack) begin
                        state_r <= S_IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= S_IDLE;
                    ready_r   <= 1'b1;
                    running_r <= 1'b0;
                    valid_r   <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_r;
    assign running   = running_r;
    assign valid     = valid_r;
    assign hit       = hit_r;
    assign overflow  = ovf_r;
    assign count_out = cap_r;

endmodule

// File: tb/tb_tdc_multichannel.sv
// Directed bench for tdc_multichannel: table of measurements plus reset and
// handshake sequences, all expectations hand-computed with latency 6.
module tb_tdc_multichannel;
    localparam logic [8:0] NEVER = 9'h1FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        edge_sel;
    logic [3:0]  ch_in;
    logic        ack;
    logic        ready;
    logic        running;
    logic        valid;
    logic [3:0]  hit;
    logic        overflow;
    logic [31:0] count_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic            edge_sel;
        logic [3:0]      ch_init;
        int              pre;
        logic [3:0][8:0] t;
        int              g_ch;
        int              g_on;
        int              g_len;
        logic [3:0][7:0] exp_cnt;
        logic [3:0]      exp_hit;
        logic            exp_ovf;
        int              exp_done;
    } vec_t;

    vec_t vecs[6];
    vec_t rv;

    tdc_multichannel #(.CH(4), .W(8), .SYNC_STAGES(3), .DEB_LEN(3)) dut (
        .clk(clk), .rst(rst), .start(start), .edge_sel(edge_sel), .ch_in(ch_in),
        .ack(ack), .ready(ready), .running(running), .valid(valid), .hit(hit),
        .overflow(overflow), .count_out(count_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic es, input logic [3:0] init, input int pre,
                                input logic [35:0] t, input int g_ch, input int g_on,
                                input int g_len, input logic [31:0] ec, input logic [3:0] eh,
                                input logic eo, input int ed);
        vec_t v;
        v.edge_sel = es;
        v.ch_init  = init;
        v.pre      = pre;
        v.t        = t;
        v.g_ch     = g_ch;
        v.g_on     = g_on;
        v.g_len    = g_len;
        v.exp_cnt  = ec;
        v.exp_hit  = eh;
        v.exp_ovf  = eo;
        v.exp_done = ed;
        return v;
    endfunction

    // Run one measurement; channel levels are driven per RUN cycle index c,
    // so a change at c is first sampled at the edge ending counter = c.
    task automatic measure(input int id, input vec_t v, input bit skip);
        int         done_c;
        logic [3:0] lvl;
        if (!skip) begin
            ch_in = 4'h0;
            repeat (12) @(negedge clk);
            ch_in = v.ch_init;
            repeat (v.pre) @(negedge clk);
        end else begin
            ch_in = v.ch_init;
        end
        chk($sformatf("v%0d idle_ready", id), {31'd0, ready}, 32'd1);
        edge_sel = v.edge_sel;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d run_flags", id), {29'd0, ready, running, valid}, 32'd2);
        done_c = -1;
        for (int c = 0; c < 400; c++) begin
            if (valid) begin
                done_c = c;
                break;
            end
            for (int i = 0; i < 4; i++) begin
                lvl[i] = v.ch_init[i];
                if (v.t[i] != NEVER && c >= int'(v.t[i])) lvl[i] = ~lvl[i];
                if (v.g_ch == i && c >= v.g_on && c < v.g_on + v.g_len) lvl[i] = ~lvl[i];
            end
            ch_in = lvl;
            ack   = (c == 1);
            @(negedge clk);
        end
        ack = 1'b0;
        chk($sformatf("v%0d done_cycle", id), done_c, v.exp_done);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("v%0d count_ch%0d", id, i), {24'd0, count_out[i*8 +: 8]},
                {24'd0, v.exp_cnt[i]});
        end
        chk($sformatf("v%0d hit", id), {28'd0, hit}, {28'd0, v.exp_hit});
        chk($sformatf("v%0d overflow", id), {31'd0, overflow}, {31'd0, v.exp_ovf});
        chk($sformatf("v%0d done_flags", id), {29'd0, ready, running, valid}, 32'd1);
    endtask

    // DONE ignores start, ack returns to IDLE with results still held
    task automatic handshake(input int id, input vec_t v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk($sformatf("v%0d start_in_done", id), {31'd0, valid}, 32'd1);
        @(negedge clk);
        chk($sformatf("v%0d done_hold_count", id), count_out, v.exp_cnt);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk($sformatf("v%0d ack_flags", id), {29'd0, ready, running, valid}, 32'd4);
        @(negedge clk);
        chk($sformatf("v%0d idle_hold_hit", id), {28'd0, hit}, {28'd0, v.exp_hit});
        chk($sformatf("v%0d idle_hold_count", id), count_out, v.exp_cnt);
        chk($sformatf("v%0d idle_hold_ovf", id), {31'd0, overflow}, {31'd0, v.exp_ovf});
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        ack      = 1'b0;
        edge_sel = 1'b0;
        ch_in    = 4'h0;

        //              es    init  pre  t {ch3,ch2,ch1,ch0}                 glitch       expected {ch3..ch0}              hit    ovf  done
        vecs[0] = mk(1'b0, 4'h0, 12, {9'd40, 9'd30, 9'd20, 9'd10}, -1, 0, 0,
                     {8'd46, 8'd36, 8'd26, 8'd16}, 4'hF, 1'b0, 47);
        vecs[1] = mk(1'b0, 4'h0, 12, {9'd40, 9'd30, 9'd50, 9'd10}, 1, 20, 2,
                     {8'd46, 8'd36, 8'd56, 8'd16}, 4'hF, 1'b0, 57);
        vecs[2] = mk(1'b0, 4'h0, 12, {NEVER, 9'd5, NEVER, 9'd5}, -1, 0, 0,
                     {8'd255, 8'd11, 8'd255, 8'd11}, 4'b0101, 1'b1, 256);
        vecs[3] = mk(1'b0, 4'h0, 12, {9'd249, 9'd30, 9'd20, 9'd10}, -1, 0, 0,
                     {8'd255, 8'd36, 8'd26, 8'd16}, 4'hF, 1'b0, 256);
        vecs[4] = mk(1'b1, 4'hF, 2, {9'd40, 9'd30, 9'd20, 9'd7}, -1, 0, 0,
                     {8'd46, 8'd36, 8'd26, 8'd13}, 4'hF, 1'b0, 47);
        vecs[5] = mk(1'b0, 4'h0, 12, {9'd3, 9'd3, 9'd3, 9'd3}, -1, 0, 0,
                     {8'd9, 8'd9, 8'd9, 8'd9}, 4'hF, 1'b0, 10);
        rv      = mk(1'b0, 4'b0001, 0, {9'd10, 9'd10, 9'd10, NEVER}, 0, 20, 10,
                     {8'd16, 8'd16, 8'd16, 8'd36}, 4'hF, 1'b0, 37);

        repeat (2) @(negedge clk);
        chk("reset_flags", {29'd0, ready, running, valid}, 32'd4);
        chk("reset_hit", {28'd0, hit}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_count", count_out, 32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            measure(k, vecs[k], 1'b0);
            handshake(k, vecs[k]);
        end

        // Abort mid-RUN: ch0 is already captured and still high when reset hits
        ch_in = 4'h0;
        repeat (12) @(negedge clk);
        edge_sel = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            ch_in = {3'b000, (c >= 10)};
            @(negedge clk);
        end
        chk("pre_reset_hit", {28'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrun_reset_flags", {29'd0, ready, running, valid}, 32'd4);
        chk("midrun_reset_hit", {28'd0, hit}, 32'd0);
        chk("midrun_reset_ovf", {31'd0, overflow}, 32'd0);
        chk("midrun_reset_count", count_out, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        measure(6, rv, 1'b1);
        handshake(6, rv);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
